sd_req_arbiter: RTL
===================

// Module: sd_req_arbiter
// PURPOSE
//  Schedules block-transfer requests from the virtual drives (FDD A, HDD, FDD B) onto the hps_io
//  sd_rd/sd_wr/sd_ack handshake, one transfer in flight at a time, granted round-robin.
//  Latches request pulses and freezes each drive's LBA at grant.
//  Generates per-drive busy (feeds CPU_WAIT), done and timeout-error pulses.
//  Replaces the per-drive ad-hoc request FSMs in the top level.
// PARAMETERS
//  NREQ     3         number of requesters; index i maps to hps_io drive slot i
//  LBA_W    32        LBA width per requester
//  TIMEOUT  24'hFFFFFF max clk cycles from sd_rd/sd_wr assert to sd_ack rise; 0 disables timeout
// PORTS
//  clk        in   1           system clock (clk_sys, 14 MHz domain)
//  reset      in   1           synchronous, active-high
//  req_rd     in   NREQ        1-cycle read request pulse per drive
//  req_wr     in   NREQ        1-cycle write request pulse per drive
//  req_lba    in   NREQ*LBA_W  LBA per drive; slice i = [i*LBA_W +: LBA_W]
//  sd_lba     out  NREQ*LBA_W  LBA to hps_io, registered copy of req_lba slice taken at grant
//  sd_rd      out  NREQ        read strobe to hps_io, at most one bit set
//  sd_wr      out  NREQ        write strobe to hps_io, at most one bit set, never with sd_rd
//  sd_ack     in   NREQ        hps_io acknowledge; high for the whole buffer transfer
//  busy       out  NREQ        drive i has a pending or in-flight transfer
//  done       out  NREQ        1-cycle pulse, transfer i completed (ack fell)
//  err        out  NREQ        1-cycle pulse, transfer i abandoned on timeout
// BEHAVIOUR
//  Reset values: sd_rd, sd_wr, done, err, busy = 0; sd_lba = 0; rr_ptr = NREQ-1; all pending bits = 0.
//  Reset is an abort: any in-flight grant is dropped and no done/err pulse is issued for it.
//  Pending: pend_rd[i] |= req_rd[i]; pend_wr[i] |= req_wr[i].
//   A pulse coincident with a clear for the same bit wins: the bit stays set.
//  busy[i] = pend_rd[i] | pend_wr[i] | (state!=IDLE && gnt==i), registered.
//  FSM, one-hot or encoded:
//   IDLE:  block while any sd_ack bit is high (stale ack after reset). Otherwise pick the first i
//          with pending rd|wr, scanning rr_ptr+1, rr_ptr+2, ... (mod NREQ).
//          Register gnt=i, op=wr if pend_wr[i] else rd (write takes priority), sd_lba slice i =
//          req_lba slice i, assert sd_wr[i]/sd_rd[i], clear tmo counter -> REQ.
//   REQ:   hold strobe. On sd_ack[gnt] rise (old=0, new=1): drop strobe next edge, clear the
//          pending bit of the served op only -> XFER.
//          If TIMEOUT!=0 and tmo==TIMEOUT-1: drop strobe, clear served pending bit,
//          err[gnt]=1 for 1 cycle, rr_ptr=gnt -> IDLE.
//   XFER:  wait for sd_ack[gnt] fall -> DONE. No timeout in XFER.
//   DONE:  done[gnt]=1 for 1 cycle, rr_ptr=gnt -> IDLE.
//  Acks on non-granted bits are ignored in every state.
//  If drive i has both rd and wr pending: write is served first, read stays pending for a later grant.
//  Latency: req pulse sampled at edge 0 -> pend set; strobe asserted at edge 1. Minimum IDLE gap
//   between back-to-back grants: 1 cycle (DONE->IDLE->REQ).
//  tmo is a LBA_W-independent 24-bit counter. It saturates and does not wrap.
//  sd_lba slice of a non-granted drive holds its last granted value.
// TESTING
//  1 Single read: req_rd[1] pulse, lba=32'h12 -> sd_rd=3'b010 one edge later, sd_lba[1]=12h;
//    ack high 5 cyc -> strobe drops after ack rise, done[1] pulse 1 cyc after ack fall, busy[1] low.
//  2 Round-robin: req_rd on all 3 in same cycle, rr_ptr reset -> grants in order 0,1,2.
//    Then a req on 0 and 2 together -> 0 granted first (rr_ptr=2).
//  3 Rd+wr on drive 2 together -> sd_wr[2] first; after done, sd_rd[2] granted; two done[2] pulses.
//  4 Timeout with TIMEOUT=16, no ack -> sd_rd held 16 cyc, err[0] pulse, busy[0]=0, next requester granted.
//  5 Reset during XFER -> next edge: all outputs 0, no done pulse.
//    Ack still high after reset -> no grant until ack low.
//  6 Re-request: req_rd[0] pulse on the ack-rise cycle -> pend stays set, second grant after done.

Source files
------------

// File: rtl/sd_req_arbiter.sv
// Round-robin scheduler of virtual-drive block requests onto the hps_io
// sd_rd/sd_wr/sd_ack handshake, with one transfer in flight at a time.
module sd_req_arbiter #(
   parameter int          NREQ    = 3,
   parameter int          LBA_W   = 32,
   parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_rd,
   input  logic [NREQ-1:0]       req_wr,
   input  logic [NREQ*LBA_W-1:0] req_lba,
   output logic [NREQ*LBA_W-1:0] sd_lba,
   output logic [NREQ-1:0]       sd_rd,
   output logic [NREQ-1:0]       sd_wr,
   input  logic [NREQ-1:0]       sd_ack,
   output logic [NREQ-1:0]       busy,
   output logic [NREQ-1:0]       done,
   output logic [NREQ-1:0]       err
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

   state_t                state, state_n;
   logic [PW-1:0]         gnt, gnt_n;
   logic [PW-1:0]         rr_ptr, rr_ptr_n;
   logic                  op_wr, op_wr_n;
   logic [NREQ-1:0]       pend_rd, pend_rd_n;
   logic [NREQ-1:0]       pend_wr, pend_wr_n;
   logic [NREQ-1:0]       ack_q;
   logic [23:0]           tmo, tmo_n;
   logic [NREQ*LBA_W-1:0] sd_lba_n;
   logic [NREQ-1:0]       sd_rd_n, sd_wr_n, busy_n, done_n, err_n;
   logic [NREQ-1:0]       clr_rd, clr_wr;
   logic                  found;
   logic [PW-1:0]         pick;
   int                    scan_idx;
   logic                  ack_rise;

   assign ack_rise = sd_ack[gnt] & ~ack_q[gnt];

   // First requester after rr_ptr (wrapping) with anything pending.
   always_comb begin
      found    = 1'b0;
      pick     = '0;
      scan_idx = 0;
      for (int k = 1; k <= NREQ; k++) begin
         scan_idx = (int'(rr_ptr) + k) % NREQ;
         if (!found && (pend_rd[scan_idx] || pend_wr[scan_idx])) begin
            found = 1'b1;
            pick  = PW'(scan_idx);
         end
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_n  = state;
      gnt_n    = gnt;
      rr_ptr_n = rr_ptr;
      op_wr_n  = op_wr;
      tmo_n    = tmo;
      sd_lba_n = sd_lba;
      sd_rd_n  = sd_rd;
      sd_wr_n  = sd_wr;
      done_n   = '0;
      err_n    = '0;
      clr_rd   = '0;
      clr_wr   = '0;

      unique case (state)
         IDLE: begin
            // A stale ack left over from before reset holds off every grant.
            if (!(|sd_ack) && found) begin
               gnt_n   = pick;
               op_wr_n = pend_wr[pick];
               sd_lba_n[int'(pick)*LBA_W +: LBA_W] = req_lba[int'(pick)*LBA_W +: LBA_W];
               sd_rd_n = '0;
               sd_wr_n = '0;
               if (pend_wr[pick]) sd_wr_n[pick] = 1'b1;
               else               sd_rd_n[pick] = 1'b1;
               tmo_n   = '0;
               state_n = REQ;
            end
         end
         REQ: begin
            if (ack_rise) begin
               sd_rd_n = '0;
               sd_wr_n = '0;
               if (op_wr) clr_wr[gnt] = 1'b1;
               else       clr_rd[gnt] = 1'b1;
               state_n = XFER;
            end else if (TIMEOUT != 24'd0 && tmo == TIMEOUT - 24'd1) begin
               sd_rd_n    = '0;
               sd_wr_n    = '0;
               if (op_wr) clr_wr[gnt] = 1'b1;
               else       clr_rd[gnt] = 1'b1;
               err_n[gnt] = 1'b1;
               rr_ptr_n   = gnt;
               state_n    = IDLE;
            end else if (tmo != '1) begin
               tmo_n = tmo + 24'd1;
            end
         end
         XFER: begin
            if (!sd_ack[gnt]) begin
               done_n[gnt] = 1'b1;
               state_n     = DONE;
            end
         end
         DONE: begin
            rr_ptr_n = gnt;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // A new pulse in the same cycle as the clear keeps the bit set.
      pend_rd_n = (pend_rd & ~clr_rd) | req_rd;
      pend_wr_n = (pend_wr & ~clr_wr) | req_wr;

      for (int i = 0; i < NREQ; i++)
         busy_n[i] = pend_rd_n[i] | pend_wr_n[i] | ((state_n != IDLE) && (gnt_n == PW'(i)));
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         gnt     <= '0;
         rr_ptr  <= PW'(NREQ - 1);
         op_wr   <= 1'b0;
         pend_rd <= '0;
         pend_wr <= '0;
         ack_q   <= '0;
         tmo     <= '0;
         sd_lba  <= '0;
         sd_rd   <= '0;
         sd_wr   <= '0;
         busy    <= '0;
         done    <= '0;
         err     <= '0;
      end else begin
         state   <= state_n;
         gnt     <= gnt_n;
         rr_ptr  <= rr_ptr_n;
         op_wr   <= op_wr_n;
         pend_rd <= pend_rd_n;
         pend_wr <= pend_wr_n;
         ack_q   <= sd_ack;
         tmo     <= tmo_n;
         sd_lba  <= sd_lba_n;
         sd_rd   <= sd_rd_n;
         sd_wr   <= sd_wr_n;
         busy    <= busy_n;
         done    <= done_n;
         err     <= err_n;
      end
   end

endmodule
